deserializer: RTL

DESERIALIZER -- requirements
Module: deserializer

---
 rtl/deserializer_if.sv | 24 ++
 rtl/deserializer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/deserializer_if.sv
// rtl/deserializer_if.sv - serial beat input and assembled-word output stream bundle
interface deserializer_if;
  logic        s_valid;
  logic [1:0]  s_in;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;

  modport master (
    input  s_valid,
    input  s_in,
    input  m_ready,
    output m_data,
    output m_valid
  );

  modport slave (
    output s_valid,
    output s_in,
    output m_ready,
    input  m_data,
    input  m_valid
  );
endinterface

// File: rtl/deserializer.sv
// rtl/deserializer.sv - 2-bit serial to 16-bit word deserializer with 2-entry output buffer
module deserializer (
  input  logic            clk,
  input  logic            rst,
  deserializer_if.master  bus,
  output logic            frame_err,
  output logic            ovf,
  output logic [7:0]      drop_cnt,
  output logic            busy
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [15:0] r_shift, w_shift_nxt;
  logic        w_push;
  logic        w_ferr;
  logic [15:0] w_word;

  logic [15:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_occ;
  logic        r_ferr;
  logic        r_ovf;
  logic [7:0]  r_drop;
  logic        w_pop;
  logic        w_full;
  logic        w_accept;
  logic        w_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_shift <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
    w_word      = {r_shift[13:0], bus.s_in};
    case (r_state)
      IDLE: begin
        if (bus.s_valid) begin
          w_shift_nxt = {14'd0, bus.s_in};
          w_cnt_nxt   = 3'd1;
          w_state_nxt = RECV;
        end
      end
      RECV: begin
        if (bus.s_valid) begin
          w_shift_nxt = w_word;
          if (r_cnt == 3'd7) begin
            // Completion returns to IDLE so a beat on the next cycle starts a new word.
            w_push      = 1'b1;
            w_cnt_nxt   = 3'd0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end else begin
          w_ferr      = 1'b1;
          w_cnt_nxt   = 3'd0;
          w_shift_nxt = 16'd0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_pop    = (r_occ != 2'd0) && bus.m_ready;
  assign w_full   = (r_occ == 2'd2);
  // A pop in the same cycle frees the head slot, so a full buffer still takes the word.
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_ovf    = w_push && w_full && !w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= 16'd0;
      r_mem[1] <= 16'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
      r_ferr   <= 1'b0;
      r_ovf    <= 1'b0;
      r_drop   <= 8'd0;
    end else begin
      r_ferr <= w_ferr;
      r_ovf  <= w_ovf;
      if (w_ovf && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign bus.m_valid = (r_occ != 2'd0);
  assign bus.m_data  = r_mem[r_rd_ptr];
  assign frame_err   = r_ferr;
  assign ovf         = r_ovf;
  assign drop_cnt    = r_drop;
  assign busy        = (r_state == RECV);

endmodule
